hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the five-stage RV64 core. It consumes the register addresses and write enables the datapath exports from the decode, execute, memory and write-back stages. It returns the stall, flush and forwarding selects that drive the datapath. It also owns the pipeline freeze for multi-cycle data-memory accesses and a timeout watchdog on those accesses.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width.
- TIMEOUT_CYCLES, 1024, consecutive memory-wait cycles before halt; 0 disables the watchdog.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_rs1_addr_dec, i_rs2_addr_dec  in  REG_ADDR_W  source addresses in decode.
- i_rs1_addr_exec, i_rs2_addr_exec  in  REG_ADDR_W  source addresses in execute.
- i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb  in  REG_ADDR_W  destination addresses.
- i_reg_we_mem, i_reg_we_wb  in  1  register write enables in MEM and WB.
- i_load_exec  in  1  execute-stage instruction is a load.
- i_pc_src_exec  in  1  taken branch or jump resolved in execute.
- i_mem_req  in  1  MEM stage holds a load or store.
- i_mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- o_flush_dec, o_flush_exec, o_flush_wb  out  1  load a bubble into IF/ID, ID/EX and MEM/WB.
- o_forward_rs1, o_forward_rs2  out  2  execute operand select.
- o_halt  out  1  sticky watchdog halt.
- o_stall_cnt, o_flush_cnt  out  CNT_WIDTH  performance counters.

## Operation
- Forwarding is combinational:
  - 2'b10 (MEM ALU result) when rsN_exec != 0, rsN_exec == rd_mem and reg_we_mem.
  - Otherwise 2'b01 (WB result) when rsN_exec != 0, rsN_exec == rd_wb and reg_we_wb.
  - Otherwise 2'b00 (register file).
  - MEM has priority over WB.
- Load-use: load_use = i_load_exec, rd_exec != 0, and rd_exec equals rs1_dec or rs2_dec.
  - Asserts stall_fetch, stall_dec and flush_exec.
- Redirect: i_pc_src_exec asserts flush_dec and flush_exec.
- Memory wait: mem_wait = i_mem_req && !i_mem_ready.
  - Asserts all four stalls and flush_wb.
  - Suppresses every other stall and flush.
- Priority, highest first: halt, mem_wait, redirect, load_use.
  - When redirect and load_use coincide, only the redirect flushes are asserted; the load-use stall is dropped because the decode instruction is on the wrong path.
- FSM, state register reset to RUN:
  - RUN -> MEM_WAIT on mem_wait.
  - MEM_WAIT -> RUN on i_mem_ready.
  - MEM_WAIT -> HALT when the wait counter reaches TIMEOUT_CYCLES.
  - HALT is left only by reset.
- Wait counter:
  - Increments each mem_wait cycle.
  - Clears when mem_wait is low.
  - Saturates at TIMEOUT_CYCLES.
- HALT:
  - o_halt = 1.
  - All four stalls and flush_wb asserted regardless of inputs.
  - No flush_dec or flush_exec.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and the registered state, with zero-cycle latency.
- A mem_wait of N cycles produces exactly N stall cycles. In the cycle i_mem_ready rises, the stalls drop and the pipeline advances.
- A redirect arriving during mem_wait is held, because execute is stalled. Its flushes appear in the first non-waiting cycle.
- o_halt is registered. It rises in the cycle after the TIMEOUT_CYCLES-th consecutive wait cycle and stays high even if i_mem_ready then rises.
- While i_arst is high:
  - State = RUN, counters = 0, o_halt = 0.
  - All stall and flush outputs are forced to 0.
  - Forwarding selects remain combinational.
- Reset asserted mid-wait or in HALT returns to RUN asynchronously.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_stall_cnt increments in every cycle where any stall output is high.
  - o_flush_cnt increments in every cycle where flush_dec or flush_exec is high.
  - Both saturate at all-ones and both reset to 0.
- HAZARD_PERF_CNT_EN undefined:
  - Counter registers are not built.
  - Both ports are tied to 0.
  - Port list is unchanged.

## Structure
- hazard_pkg holds:
  - forward select constants FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the FSM state enum (RUN, MEM_WAIT, HALT).
- Sub-module forwarding_select is combinational. It maps one execute source address plus the MEM and WB destination/enable pairs to a 2-bit select, and is instantiated twice (rs1, rs2).
- The top level holds the priority logic, FSM, wait counter and optional counters.

## Test plan
- rd_mem = 5, we_mem = 1, rd_wb = 5, we_wb = 1, rs1_exec = 5 -> forward_rs1 = 2'b10. With we_mem = 0 -> 2'b01.
- rs2_exec = 0, rd_mem = 0, we_mem = 1 -> forward_rs2 = 2'b00.
- load_exec = 1, rd_exec = 7, rs2_dec = 7 for one cycle -> stall_fetch = stall_dec = flush_exec = 1 for that cycle only; flush_dec = 0.
- Same load-use with pc_src_exec = 1 -> flush_dec = flush_exec = 1 and stall_fetch = stall_dec = 0.
- mem_req = 1, mem_ready low for 3 cycles then high, with a redirect pending:
  - All stalls and flush_wb are high for exactly 3 cycles.
  - flush_dec and flush_exec appear in the 4th cycle.
  - o_stall_cnt = 3 with HAZARD_PERF_CNT_EN.
- TIMEOUT_CYCLES = 4, mem_ready held low:
  - o_halt rises after the 4th wait cycle and stays high after mem_ready = 1.
  - i_arst clears it and all outputs go to 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select codes and
// the memory-wait/watchdog FSM state encoding.
package hazard_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

endpackage

// File: rtl/forwarding_select.sv
// Combinational operand-forwarding select for one execute-stage source register.
// The MEM-stage result is newer than the WB-stage result, so it wins.
module forwarding_select
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_rs_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
   input  logic                  i_reg_we_mem,
   input  logic                  i_reg_we_wb,
   output logic [1:0]            o_forward
);

   always_comb begin
      // NOTE: default first so every path assigns o_forward and no latch is inferred.
      o_forward = FWD_REG;
      if (i_rs_addr != '0) begin
         if (i_reg_we_mem && (i_rs_addr == i_rd_addr_mem)) begin
            o_forward = FWD_MEM;
         end else if (i_reg_we_wb && (i_rs_addr == i_rd_addr_wb)) begin
            o_forward = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, redirect
// flush, memory-wait freeze and watchdog halt. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
   input  logic                  i_reg_we_mem,
   input  logic                  i_reg_we_wb,
   input  logic                  i_load_exec,
   input  logic                  i_pc_src_exec,
   input  logic                  i_mem_req,
   input  logic                  i_mem_ready,
   output logic                  o_stall_fetch,
   output logic                  o_stall_dec,
   output logic                  o_stall_exec,
   output logic                  o_stall_mem,
   output logic                  o_flush_dec,
   output logic                  o_flush_exec,
   output logic                  o_flush_wb,
   output logic [1:0]            o_forward_rs1,
   output logic [1:0]            o_forward_rs2,
   output logic                  o_halt,
   output logic [CNT_WIDTH-1:0]  o_stall_cnt,
   output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

   state_t            r_state;
   state_t            w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_next;
   logic              w_mem_wait;
   logic              w_load_use;
   logic              w_timeout;
   logic              w_halted;

   forwarding_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .i_rs_addr     (i_rs1_addr_exec),
      .i_rd_addr_mem (i_rd_addr_mem),
      .i_rd_addr_wb  (i_rd_addr_wb),
      .i_reg_we_mem  (i_reg_we_mem),
      .i_reg_we_wb   (i_reg_we_wb),
      .o_forward     (o_forward_rs1)
   );

   forwarding_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .i_rs_addr     (i_rs2_addr_exec),
      .i_rd_addr_mem (i_rd_addr_mem),
      .i_rd_addr_wb  (i_rd_addr_wb),
      .i_reg_we_mem  (i_reg_we_mem),
      .i_reg_we_wb   (i_reg_we_wb),
      .o_forward     (o_forward_rs2)
   );

   assign w_mem_wait = i_mem_req && !i_mem_ready;
   assign w_load_use = i_load_exec && (i_rd_addr_exec != '0) &&
                       ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));
   assign w_halted   = (r_state == HALT);
   assign o_halt     = w_halted;

   always_comb begin
      w_wait_cnt_next = '0;
      if (w_mem_wait) begin
         w_wait_cnt_next = (r_wait_cnt == TIMEOUT_VAL) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
      end
   end

   // Halt is taken on the edge that closes the TIMEOUT_CYCLES-th wait cycle.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && w_mem_wait && (w_wait_cnt_next == TIMEOUT_VAL);

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         RUN: begin
            if (w_mem_wait) w_state_next = w_timeout ? HALT : MEM_WAIT;
         end
         MEM_WAIT: begin
            if (w_timeout)       w_state_next = HALT;
            else if (!w_mem_wait) w_state_next = RUN;
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = RUN;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (i_arst) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
      end
   end

   always_comb begin
      o_stall_fetch = 1'b0;
      o_stall_dec   = 1'b0;
      o_stall_exec  = 1'b0;
      o_stall_mem   = 1'b0;
      o_flush_dec   = 1'b0;
      o_flush_exec  = 1'b0;
      o_flush_wb    = 1'b0;
      if (i_arst) begin
         // Reset holds all control outputs low.
      end else if (w_halted || w_mem_wait) begin
         o_stall_fetch = 1'b1;
         o_stall_dec   = 1'b1;
         o_stall_exec  = 1'b1;
         o_stall_mem   = 1'b1;
         o_flush_wb    = 1'b1;
      end else if (i_pc_src_exec) begin
         // The decode instruction is on the wrong path, so any load-use stall is moot.
         o_flush_dec   = 1'b1;
         o_flush_exec  = 1'b1;
      end else if (w_load_use) begin
         o_stall_fetch = 1'b1;
         o_stall_dec   = 1'b1;
         o_flush_exec  = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;
   logic                 w_any_stall;
   logic                 w_any_flush;

   assign w_any_stall = o_stall_fetch || o_stall_dec || o_stall_exec || o_stall_mem;
   assign w_any_flush = o_flush_dec || o_flush_exec;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_any_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         if (w_any_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit, built with TIMEOUT_CYCLES = 4.
module tb_hazard_control_unit;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 32;

   // Control vector order: {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec, flush_wb}
   localparam logic [6:0] CTL_IDLE     = 7'b0000_000;
   localparam logic [6:0] CTL_FREEZE   = 7'b1111_001;
   localparam logic [6:0] CTL_REDIRECT = 7'b0000_110;
   localparam logic [6:0] CTL_LOADUSE  = 7'b1100_010;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CW-1:0] EXP_STALL_CNT = 32'd3;
   localparam logic [CW-1:0] EXP_FLUSH_CNT = 32'd1;
`else
   localparam logic [CW-1:0] EXP_STALL_CNT = 32'd0;
   localparam logic [CW-1:0] EXP_FLUSH_CNT = 32'd0;
`endif

   logic          clk = 1'b0;
   logic          arst;
   logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
   logic          we_mem, we_wb, load_exec, pc_src, mem_req, mem_ready;
   logic          stall_fetch, stall_dec, stall_exec, stall_mem;
   logic          flush_dec, flush_exec, flush_wb, halt;
   logic [1:0]    fwd1, fwd2;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [6:0]    ctl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ctl = {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec, flush_wb};

   hazard_control_unit #(.REG_ADDR_W(AW), .TIMEOUT_CYCLES(4), .CNT_WIDTH(CW)) dut (
      .i_clk           (clk),
      .i_arst          (arst),
      .i_rs1_addr_dec  (rs1_dec),
      .i_rs2_addr_dec  (rs2_dec),
      .i_rs1_addr_exec (rs1_exec),
      .i_rs2_addr_exec (rs2_exec),
      .i_rd_addr_exec  (rd_exec),
      .i_rd_addr_mem   (rd_mem),
      .i_rd_addr_wb    (rd_wb),
      .i_reg_we_mem    (we_mem),
      .i_reg_we_wb     (we_wb),
      .i_load_exec     (load_exec),
      .i_pc_src_exec   (pc_src),
      .i_mem_req       (mem_req),
      .i_mem_ready     (mem_ready),
      .o_stall_fetch   (stall_fetch),
      .o_stall_dec     (stall_dec),
      .o_stall_exec    (stall_exec),
      .o_stall_mem     (stall_mem),
      .o_flush_dec     (flush_dec),
      .o_flush_exec    (flush_exec),
      .o_flush_wb      (flush_wb),
      .o_forward_rs1   (fwd1),
      .o_forward_rs2   (fwd2),
      .o_halt          (halt),
      .o_stall_cnt     (stall_cnt),
      .o_flush_cnt     (flush_cnt)
   );

   task automatic idle_inputs();
      rs1_dec = '0; rs2_dec = '0; rs1_exec = '0; rs2_exec = '0;
      rd_exec = '0; rd_mem = '0; rd_wb = '0;
      we_mem = 1'b0; we_wb = 1'b0; load_exec = 1'b0; pc_src = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      next_cycle();
      arst = 1'b1;
      #2;
      arst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      arst = 1'b1;
      mem_req = 1'b1; pc_src = 1'b1; load_exec = 1'b1; rd_exec = 5'd7; rs1_dec = 5'd7;
      rs1_exec = 5'd5; rd_mem = 5'd5; we_mem = 1'b1;
      repeat (2) next_cycle();
      #2;
      n_checks++;
      if (ctl !== CTL_IDLE) begin
         n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE);
      end
      n_checks++;
      if (halt !== 1'b0) begin
         n_fail++; $display("FAIL reset_halt: got %b expected 0", halt);
      end
      n_checks++;
      if (fwd1 !== 2'b10) begin
         n_fail++; $display("FAIL reset_fwd_comb: got %b expected 10", fwd1);
      end
      n_checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      end
      idle_inputs();
      #1;
      arst = 1'b0;
   endtask

   typedef struct {
      logic [AW-1:0] rs1, rs2, rdm, rdw;
      logic          wem, wew;
      logic [1:0]    e1, e2;
   } fwd_vec_t;

   task automatic test_forwarding();
      fwd_vec_t v [6];
      v[0] = '{rs1: 5'd5,  rs2: 5'd0,  rdm: 5'd5,  rdw: 5'd5,  wem: 1'b1, wew: 1'b1, e1: 2'b10, e2: 2'b00};
      v[1] = '{rs1: 5'd5,  rs2: 5'd0,  rdm: 5'd5,  rdw: 5'd5,  wem: 1'b0, wew: 1'b1, e1: 2'b01, e2: 2'b00};
      v[2] = '{rs1: 5'd3,  rs2: 5'd0,  rdm: 5'd0,  rdw: 5'd0,  wem: 1'b1, wew: 1'b1, e1: 2'b00, e2: 2'b00};
      v[3] = '{rs1: 5'd9,  rs2: 5'd12, rdm: 5'd9,  rdw: 5'd12, wem: 1'b1, wew: 1'b1, e1: 2'b10, e2: 2'b01};
      v[4] = '{rs1: 5'd12, rs2: 5'd9,  rdm: 5'd9,  rdw: 5'd12, wem: 1'b1, wew: 1'b0, e1: 2'b00, e2: 2'b10};
      v[5] = '{rs1: 5'd31, rs2: 5'd31, rdm: 5'd30, rdw: 5'd31, wem: 1'b1, wew: 1'b1, e1: 2'b01, e2: 2'b01};
      for (int i = 0; i < 6; i++) begin
         rs1_exec = v[i].rs1; rs2_exec = v[i].rs2; rd_mem = v[i].rdm; rd_wb = v[i].rdw;
         we_mem = v[i].wem; we_wb = v[i].wew;
         #1;
         n_checks++;
         if (fwd1 !== v[i].e1) begin
            n_fail++; $display("FAIL fwd_rs1[%0d]: got %b expected %b", i, fwd1, v[i].e1);
         end
         n_checks++;
         if (fwd2 !== v[i].e2) begin
            n_fail++; $display("FAIL fwd_rs2[%0d]: got %b expected %b", i, fwd2, v[i].e2);
         end
      end
      idle_inputs();
   endtask

   task automatic test_load_use();
      pulse_reset();
      next_cycle();
      load_exec = 1'b1; rd_exec = 5'd7; rs2_dec = 5'd7; rs1_dec = 5'd3;
      #2;
      n_checks++;
      if (ctl !== CTL_LOADUSE) begin
         n_fail++; $display("FAIL load_use_rs2: got %b expected %b", ctl, CTL_LOADUSE);
      end
      next_cycle();
      load_exec = 1'b0;
      #2;
      n_checks++;
      if (ctl !== CTL_IDLE) begin
         n_fail++; $display("FAIL load_use_one_cycle: got %b expected %b", ctl, CTL_IDLE);
      end
      next_cycle();
      load_exec = 1'b1; rd_exec = 5'd4; rs1_dec = 5'd4; rs2_dec = 5'd1;
      #2;
      n_checks++;
      if (ctl !== CTL_LOADUSE) begin
         n_fail++; $display("FAIL load_use_rs1: got %b expected %b", ctl, CTL_LOADUSE);
      end
      next_cycle();
      rd_exec = 5'd0; rs1_dec = 5'd0;
      #2;
      n_checks++;
      if (ctl !== CTL_IDLE) begin
         n_fail++; $display("FAIL load_use_x0: got %b expected %b", ctl, CTL_IDLE);
      end
      idle_inputs();
   endtask

   task automatic test_redirect();
      next_cycle();
      pc_src = 1'b1;
      #2;
      n_checks++;
      if (ctl !== CTL_REDIRECT) begin
         n_fail++; $display("FAIL redirect: got %b expected %b", ctl, CTL_REDIRECT);
      end
      next_cycle();
      load_exec = 1'b1; rd_exec = 5'd7; rs2_dec = 5'd7;
      #2;
      n_checks++;
      if (ctl !== CTL_REDIRECT) begin
         n_fail++; $display("FAIL redirect_over_load_use: got %b expected %b", ctl, CTL_REDIRECT);
      end
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      pulse_reset();
      next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0; pc_src = 1'b1;
      load_exec = 1'b1; rd_exec = 5'd2; rs1_dec = 5'd2;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++;
         if (ctl !== CTL_FREEZE || halt !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_cycle%0d: got ctl=%b halt=%b expected ctl=%b halt=0", i, ctl, halt, CTL_FREEZE);
         end
         next_cycle();
      end
      mem_ready = 1'b1;
      #2;
      n_checks++;
      if (ctl !== CTL_REDIRECT) begin
         n_fail++; $display("FAIL mem_wait_release_redirect: got %b expected %b", ctl, CTL_REDIRECT);
      end
      next_cycle();
      idle_inputs();
      #2;
      n_checks++;
      if (stall_cnt !== EXP_STALL_CNT) begin
         n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, EXP_STALL_CNT);
      end
      n_checks++;
      if (flush_cnt !== EXP_FLUSH_CNT) begin
         n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, EXP_FLUSH_CNT);
      end
      n_checks++;
      if (halt !== 1'b0) begin
         n_fail++; $display("FAIL mem_wait_no_halt: got %b expected 0", halt);
      end
   endtask

   task automatic test_timeout_halt();
      pulse_reset();
      next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         n_checks++;
         if (halt !== 1'b0 || ctl !== CTL_FREEZE) begin
            n_fail++; $display("FAIL timeout_wait%0d: got halt=%b ctl=%b expected halt=0 ctl=%b", i, halt, ctl, CTL_FREEZE);
         end
         next_cycle();
      end
      #2;
      n_checks++;
      if (halt !== 1'b1) begin
         n_fail++; $display("FAIL halt_rise: got %b expected 1", halt);
      end
      mem_ready = 1'b1; pc_src = 1'b1;
      load_exec = 1'b1; rd_exec = 5'd6; rs2_dec = 5'd6;
      #1;
      n_checks++;
      if (ctl !== CTL_FREEZE) begin
         n_fail++; $display("FAIL halt_ctl: got %b expected %b", ctl, CTL_FREEZE);
      end
      next_cycle();
      #2;
      n_checks++;
      if (halt !== 1'b1) begin
         n_fail++; $display("FAIL halt_sticky: got %b expected 1", halt);
      end
      arst = 1'b1;
      #1;
      n_checks++;
      if (halt !== 1'b0 || ctl !== CTL_IDLE) begin
         n_fail++; $display("FAIL halt_async_clear: got halt=%b ctl=%b expected halt=0 ctl=%b", halt, ctl, CTL_IDLE);
      end
      n_checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         n_fail++; $display("FAIL halt_cnt_clear: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      end
      idle_inputs();
      next_cycle();
      arst = 1'b0;
      next_cycle();
      #2;
      n_checks++;
      if (halt !== 1'b0 || ctl !== CTL_IDLE) begin
         n_fail++; $display("FAIL after_reset_run: got halt=%b ctl=%b expected halt=0 ctl=%b", halt, ctl, CTL_IDLE);
      end
   endtask

   initial begin
      arst = 1'b1;
      idle_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_timeout_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
